// File: rtl/uart_block_framer_if.sv
// uart_block_framer_if: UART byte side and AES block side of the framer.
//   slave  : the framer (consumes rx bytes / blk_in, produces blocks / tx bytes)
//   master : the environment driving the framer (UART core + AES core)
//   uart_rx_ready, uart_data_from_rx : received byte strobe and data
//   uart_tx_ready, uart_data_to_tx, uart_tx_enable : transmit handshake
//   blk_out, blk_out_valid, blk_out_ready : assembled block to AES
//   blk_in, blk_in_valid, blk_in_ready   : result block from AES
//   rx_overrun, rx_timeout               : receive status
interface uart_block_framer_if;
    logic         uart_rx_ready;
    logic [7:0]   uart_data_from_rx;
    logic         uart_tx_ready;
    logic [7:0]   uart_data_to_tx;
    logic         uart_tx_enable;
    logic [127:0] blk_out;
    logic         blk_out_valid;
    logic         blk_out_ready;
    logic [127:0] blk_in;
    logic         blk_in_valid;
    logic         blk_in_ready;
    logic         rx_overrun;
    logic         rx_timeout;

    modport slave (
        input  uart_rx_ready, uart_data_from_rx, uart_tx_ready, blk_out_ready, blk_in, blk_in_valid,
        output uart_data_to_tx, uart_tx_enable, blk_out, blk_out_valid, blk_in_ready, rx_overrun, rx_timeout
    );

    modport master (
        output uart_rx_ready, uart_data_from_rx, uart_tx_ready, blk_out_ready, blk_in, blk_in_valid,
        input  uart_data_to_tx, uart_tx_enable, blk_out, blk_out_valid, blk_in_ready, rx_overrun, rx_timeout
    );
endinterface

// File: rtl/uart_block_framer.sv
// uart_block_framer: packs 16 UART bytes into a 128-bit AES block and serialises result blocks back out.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : uart_block_framer_if.slave carrying the UART byte handshakes, the
//          blk_out/blk_in valid/ready handshakes and the rx_overrun/rx_timeout status
// Both paths are big-endian: first byte on the wire is bits [127:120].
module uart_block_framer #(
    parameter int TIMEOUT_CYCLES = 4800000,
    parameter int TX_HOLDOFF     = 2
) (
    input logic               clk,
    input logic               rst,
    uart_block_framer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(TX_HOLDOFF + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] H_LOAD = HW'(TX_HOLDOFF);

    typedef enum logic {R_COLLECT, R_FULL} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_WAIT, T_SEND} tx_state_t;

    rx_state_t     rx_state, rx_state_d;
    tx_state_t     tx_state, tx_state_d;
    logic [127:0]  rx_shift, tx_shift;
    logic [3:0]    rx_cnt, tx_cnt;
    logic [TW-1:0] timer;
    logic [HW-1:0] holdoff;
    logic [7:0]    tx_data;
    logic          overrun, timeout;
    logic          rx_take, rx_expire, tx_load, tx_go;

    // RX: bytes shift in at the bottom, so after 16 bytes the first one sits in [127:120].
    // Expiry wins over completion: a byte coinciding with expiry starts a new block.
    always_comb begin
        rx_take    = rx_state == R_COLLECT && bus.uart_rx_ready;
        rx_expire  = rx_state == R_COLLECT && rx_cnt != 4'd0 && timer == T_LAST;
        rx_state_d = rx_state == R_COLLECT
                   ? ((rx_take && rx_cnt == 4'd15 && !rx_expire) ? R_FULL : R_COLLECT)
                   : (bus.blk_out_ready ? R_COLLECT : R_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_COLLECT;
            rx_shift <= '0;
            rx_cnt   <= '0;
            timer    <= '0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            timeout  <= rx_expire;
            if (rx_take)
                rx_shift <= {rx_shift[119:0], bus.uart_data_from_rx};
            if (rx_state == R_FULL && bus.uart_rx_ready)
                overrun <= 1'b1;
            // rx_cnt wraps 15 -> 0 on the 16th byte, so it is already 0 in R_FULL
            rx_cnt <= rx_expire ? {3'd0, rx_take} : rx_take ? rx_cnt + 4'd1 : rx_cnt;
            timer  <= (rx_take || rx_expire || rx_state != R_COLLECT || rx_cnt == 4'd0)
                    ? '0 : timer + TW'(1);
        end
    end

    // TX: the byte is latched on entry to T_SEND so it is on uart_data_to_tx
    // during the enable strobe and holds until the next send.
    always_comb begin
        tx_load    = tx_state == T_IDLE && bus.blk_in_valid;
        tx_go      = tx_state == T_WAIT && holdoff == '0 && bus.uart_tx_ready;
        tx_state_d = tx_state == T_IDLE ? (bus.blk_in_valid ? T_WAIT : T_IDLE)
                   : tx_state == T_WAIT ? (tx_go ? T_SEND : T_WAIT)
                   : (tx_cnt == 4'd15 ? T_IDLE : T_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            holdoff  <= '0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_d;
            if (tx_load)
                tx_shift <= bus.blk_in;
            else if (tx_go)
                tx_shift <= {tx_shift[119:0], 8'h00};
            if (tx_go)
                tx_data <= tx_shift[127:120];
            tx_cnt  <= tx_load ? 4'd0 : tx_state == T_SEND ? tx_cnt + 4'd1 : tx_cnt;
            // holdoff masks uart_tx_ready for a few cycles after each strobe,
            // covering the UART core's latency in dropping its ready flag
            holdoff <= tx_state == T_SEND ? H_LOAD : holdoff != '0 ? holdoff - HW'(1) : holdoff;
        end
    end

    assign bus.blk_out         = rx_shift;
    assign bus.blk_out_valid   = rx_state == R_FULL;
    assign bus.blk_in_ready    = tx_state == T_IDLE;
    assign bus.uart_tx_enable  = tx_state == T_SEND;
    assign bus.uart_data_to_tx = tx_data;
    assign bus.rx_overrun      = overrun;
    assign bus.rx_timeout      = timeout;
endmodule

// File: tb/tb_uart_block_framer.sv
// tb_uart_block_framer: directed + randomized checks of uart_block_framer against a byte-queue reference model.
module tb_uart_block_framer;
    localparam int TO = 100;
    localparam int HO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_block_framer_if bus();
    uart_block_framer #(.TIMEOUT_CYCLES(TO), .TX_HOLDOFF(HO)) dut (.clk(clk), .rst(rst), .bus(bus));

    // observation records, filled on the falling edge
    logic [7:0]   tx_bytes[$];
    int           tx_times[$];
    logic [127:0] blocks[$];
    int           to_times[$];
    int           valid_cycles = 0;
    int           busy = 0;
    int           busy_len = 50;
    int           last_rx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model: busy for busy_len cycles after each enable
    always @(negedge clk) begin
        if (bus.uart_tx_enable === 1'b1) begin
            tx_bytes.push_back(bus.uart_data_to_tx);
            tx_times.push_back(cyc);
            busy = busy_len;
        end else if (busy > 0)
            busy--;
        bus.uart_tx_ready = (busy == 0);
        if (bus.blk_out_valid === 1'b1)
            valid_cycles++;
        if (bus.blk_out_valid === 1'b1 && bus.blk_out_ready === 1'b1)
            blocks.push_back(bus.blk_out);
        if (bus.rx_timeout === 1'b1)
            to_times.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] want);
        n_checks++;
        assert (o === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, want);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        bus.uart_rx_ready = 1'b1;
        bus.uart_data_from_rx = b;
        last_rx = cyc;
        tick(1);
        bus.uart_rx_ready = 1'b0;
        tick(gap);
    endtask

    // big-endian: byte i of the wire order occupies bits [127-8i -: 8]
    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = q[i];
        return r;
    endfunction

    task automatic rx_block(input int gap, output logic [127:0] want);
        logic [7:0] q[$];
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, gap);
        end
        want = pack(q);
    endtask

    task automatic send_tx(input logic [127:0] b);
        int n = 0;
        while (bus.blk_in_ready !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        bus.blk_in = b;
        bus.blk_in_valid = 1'b1;
        tick(1);
        bus.blk_in_valid = 1'b0;
    endtask

    task automatic wait_tx(input int base, input int n, output int ready_hi);
        int budget = 3000;
        ready_hi = 0;
        while (tx_bytes.size() - base < n && budget > 0) begin
            tick(1);
            budget--;
            if (bus.blk_in_ready === 1'b1 && tx_bytes.size() - base < n)
                ready_hi++;
        end
    endtask

    initial begin
        logic [127:0] want, tblk;
        logic [7:0]   q[$];
        logic [7:0]   b;
        int nb, nt, vc, k, rh, bad;

        bus.uart_rx_ready = 1'b0;
        bus.uart_data_from_rx = 8'h00;
        bus.blk_out_ready = 1'b0;
        bus.blk_in = '0;
        bus.blk_in_valid = 1'b0;
        tick(3);
        rst = 1'b0;

        // reset state
        chk("rst_blk_out_valid", 128'(bus.blk_out_valid), 128'(0));
        chk("rst_blk_in_ready", 128'(bus.blk_in_ready), 128'(1));
        chk("rst_tx_enable", 128'(bus.uart_tx_enable), 128'(0));
        chk("rst_data_to_tx", 128'(bus.uart_data_to_tx), 128'(0));
        chk("rst_blk_out", bus.blk_out, 128'(0));
        chk("rst_overrun", 128'(bus.rx_overrun), 128'(0));
        chk("rst_timeout", 128'(bus.rx_timeout), 128'(0));

        // bytes 0x00..0x0F, AES always ready
        bus.blk_out_ready = 1'b1;
        nb = blocks.size();
        vc = valid_cycles;
        for (int i = 0; i < 16; i++)
            send_rx(8'(i), 3);
        tick(2);
        chk("seq_block_count", 128'(blocks.size() - nb), 128'(1));
        chk("seq_block_data", blocks[$], 128'h000102030405060708090a0b0c0d0e0f);
        chk("seq_valid_one_cycle", 128'(valid_cycles - vc), 128'(1));
        chk("seq_no_overrun", 128'(bus.rx_overrun), 128'(0));

        // back-pressure, overrun byte, and a byte in the handshake cycle
        bus.blk_out_ready = 1'b0;
        rx_block(2, want);
        tick(2);
        chk("full_valid", 128'(bus.blk_out_valid), 128'(1));
        chk("full_data", bus.blk_out, want);
        send_rx(8'hAA, 3);
        chk("overrun_set", 128'(bus.rx_overrun), 128'(1));
        chk("full_held", bus.blk_out, want);
        nb = blocks.size();
        bus.blk_out_ready = 1'b1;
        send_rx(8'hBB, 1);
        chk("bp_handshake_count", 128'(blocks.size() - nb), 128'(1));
        chk("bp_handshake_data", blocks[$], want);
        chk("bp_valid_dropped", 128'(bus.blk_out_valid), 128'(0));
        rx_block(2, want);
        tick(2);
        chk("after_overrun_block", blocks[$], want);

        // inter-byte timeout on a 5-byte partial block
        nt = to_times.size();
        for (int i = 0; i < 5; i++)
            send_rx(8'($urandom), 3);
        k = last_rx;
        tick(TO + 20);
        chk("timeout_count", 128'(to_times.size() - nt), 128'(1));
        chk("timeout_cycle", 128'(to_times[$]), 128'(k + 1 + TO));
        chk("timeout_no_valid", 128'(bus.blk_out_valid), 128'(0));
        nb = blocks.size();
        rx_block(3, want);
        tick(2);
        chk("post_timeout_count", 128'(blocks.size() - nb), 128'(1));
        chk("post_timeout_block", blocks[$], want);
        chk("no_spurious_timeout", 128'(to_times.size() - nt), 128'(1));

        // byte arriving in the very cycle the timer expires starts a new block
        nt = to_times.size();
        for (int i = 0; i < 3; i++)
            send_rx(8'($urandom), 3);
        k = last_rx;
        tick(k + TO - cyc);
        q = {};
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 2);
        end
        tick(2);
        chk("edge_timeout_cycle", 128'(to_times[$]), 128'(k + 1 + TO));
        chk("edge_timeout_count", 128'(to_times.size() - nt), 128'(1));
        chk("edge_timeout_block", blocks[$], pack(q));

        // TX with slow UART
        busy_len = 50;
        nt = tx_bytes.size();
        tblk = 128'h00112233445566778899aabbccddeeff;
        send_tx(tblk);
        wait_tx(nt, 16, rh);
        chk("tx_count", 128'(tx_bytes.size() - nt), 128'(16));
        for (int i = 0; i < 16; i++)
            chk("tx_byte", 128'(tx_bytes[nt+i]), 128'(tblk[127-8*i -: 8]));
        chk("tx_ready_low_while_busy", 128'(rh), 128'(0));
        chk("tx_ready_after", 128'(bus.blk_in_ready), 128'(1));
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (tx_times[nt+i] - tx_times[nt+i-1] < HO + 2) bad++;
        chk("tx_spacing_min", 128'(bad), 128'(0));

        // reset after the 7th TX byte and the 9th RX byte
        nt = tx_bytes.size();
        k = to_times.size();
        send_tx({$urandom, $urandom, $urandom, $urandom});
        wait_tx(nt, 7, rh);
        for (int i = 0; i < 9; i++)
            send_rx(8'($urandom), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_blk_in_ready", 128'(bus.blk_in_ready), 128'(1));
        chk("mid_rst_blk_out_valid", 128'(bus.blk_out_valid), 128'(0));
        chk("mid_rst_tx_enable", 128'(bus.uart_tx_enable), 128'(0));
        chk("mid_rst_data_to_tx", 128'(bus.uart_data_to_tx), 128'(0));
        chk("mid_rst_overrun", 128'(bus.rx_overrun), 128'(0));
        tick(300);
        chk("mid_rst_no_more_tx", 128'(tx_bytes.size() - nt), 128'(7));
        chk("mid_rst_no_timeout", 128'(to_times.size() - k), 128'(0));
        nb = blocks.size();
        rx_block(2, want);
        tick(2);
        chk("mid_rst_fresh_count", 128'(blocks.size() - nb), 128'(1));
        chk("mid_rst_fresh_block", blocks[$], want);

        // full duplex with an always-ready UART
        busy_len = 0;
        tick(60);
        nt = tx_bytes.size();
        nb = blocks.size();
        tblk = {$urandom, $urandom, $urandom, $urandom};
        send_tx(tblk);
        rx_block(0, want);
        wait_tx(nt, 16, rh);
        tick(10);
        chk("fd_rx_count", 128'(blocks.size() - nb), 128'(1));
        chk("fd_rx_block", blocks[$], want);
        chk("fd_tx_count", 128'(tx_bytes.size() - nt), 128'(16));
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (tx_bytes[nt+i] !== tblk[127-8*i -: 8]) bad++;
        chk("fd_tx_bytes", 128'(bad), 128'(0));
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (tx_times[nt+i] - tx_times[nt+i-1] != HO + 2) bad++;
        chk("fd_tx_spacing_exact", 128'(bad), 128'(0));
        chk("fd_tx_ready_low", 128'(rh), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_block_framer.md
Name: uart_block_framer

Overview:
- Sits between the byte-wide UART core and the AES core, on the 48 MHz PLL clock domain.
- RX path: assembles 16 UART bytes into one 128-bit block and hands it to AES over a valid/ready handshake.
- TX path: accepts a 128-bit result block over valid/ready and serialises it back to the UART one byte at a time.
- An inter-byte timeout discards partial blocks so a host that drops bytes regains alignment.

Parameters:
TIMEOUT_CYCLES, 4800000, idle cycles after a byte, with a partial block pending, before the partial block is discarded (100 ms at 48 MHz); must be ≥2
TX_HOLDOFF, 2, cycles after a uart_tx_enable pulse during which uart_tx_ready is ignored; must be ≥1

Ports:
clk  in  1  system clock (PLL output)
rst  in  1  reset, synchronous, active-high
uart_rx_ready  in  1  one-cycle strobe: uart_data_from_rx holds a new byte
uart_data_from_rx  in  8  received byte
uart_tx_ready  in  1  level: UART transmitter idle and able to accept a byte
uart_data_to_tx  out  8  byte to transmit
uart_tx_enable  out  1  one-cycle strobe: start transmitting uart_data_to_tx
blk_out  out  128  assembled block to AES
blk_out_valid  out  1  blk_out holds a complete block
blk_out_ready  in  1  AES accepts blk_out
blk_in  in  128  result block from AES
blk_in_valid  in  1  blk_in is valid
blk_in_ready  out  1  framer can accept blk_in
rx_overrun  out  1  sticky: a byte arrived while a full block was pending
rx_timeout  out  1  one-cycle pulse: a partial block was discarded

Behaviour:
- Reset (synchronous, active-high) at a clk edge with rst=1:
  - Both FSMs go idle; byte counts and timeout timer go to 0.
  - blk_out_valid=0, blk_in_ready=1 in the cycle after reset, uart_tx_enable=0, uart_data_to_tx=0, blk_out=0, rx_overrun=0, rx_timeout=0.
  - Reset mid-block or mid-transmission abandons all in-flight data; no further strobes are issued.
- Byte order is big-endian (FIPS-197):
  - RX: the first byte received lands in blk_out[127:120], the 16th in [7:0].
  - TX: blk_in[127:120] is sent first.
- RX FSM states R_COLLECT and R_FULL:
  - R_COLLECT: each uart_rx_ready strobe writes the byte into shift register slot rx_cnt, and rx_cnt increments (4-bit).
  - On the 16th byte, go to R_FULL; blk_out_valid rises the following cycle, together with the complete blk_out.
  - R_FULL: blk_out and blk_out_valid are held stable until a cycle with blk_out_ready=1. After that cycle: blk_out_valid=0, rx_cnt=0, state R_COLLECT.
  - Bytes arriving in R_FULL are dropped and set rx_overrun (cleared only by rst).
  - A byte strobe in the same cycle as the blk_out_ready handshake is also dropped and sets rx_overrun.
  - blk_out is undefined-but-stable while blk_out_valid=0; verification must not check it then.
- Timeout (RX):
  - The timer clears on every uart_rx_ready strobe.
  - It counts only while in R_COLLECT with rx_cnt≠0.
  - When it reaches TIMEOUT_CYCLES: rx_cnt→0, timer→0, rx_timeout pulses high for exactly 1 cycle.
  - A byte strobe in the same cycle the timer expires counts as the first byte of a new block (rx_cnt→1) and still pulses rx_timeout.
- TX FSM states T_IDLE, T_WAIT, T_SEND:
  - blk_in_ready=1 only in T_IDLE.
  - T_IDLE: when blk_in_valid=1, capture blk_in into the shift register, set tx_cnt=0, go to T_WAIT.
  - T_WAIT: wait until holdoff counter=0 and uart_tx_ready=1, then go to T_SEND.
  - T_SEND (exactly 1 cycle): uart_tx_enable=1, uart_data_to_tx = shift[127:120]; shift left 8; tx_cnt++; holdoff loaded with TX_HOLDOFF.
    - If tx_cnt was 15, go to T_IDLE; otherwise go to T_WAIT.
  - uart_data_to_tx holds the last byte sent until the next T_SEND.
  - Minimum spacing between enable strobes is TX_HOLDOFF+2 cycles.
  - uart_tx_enable is never asserted for 2 consecutive cycles.
- The RX and TX paths are fully independent: simultaneous rx strobe and tx send is legal and both progress.

Test Plan:
- Reset, then 16 rx strobes with bytes 0x00..0x0F (3-cycle gaps), blk_out_ready=1 → blk_out_valid pulses 1 cycle, blk_out=0x000102030405060708090A0B0C0D0E0F, rx_cnt returns 0.
- blk_out_ready=0: send 16 bytes, then a 17th byte 0xAA, then raise blk_out_ready → blk_out unchanged until the handshake, rx_overrun=1, 0xAA absent from the next block.
- Send 5 bytes, idle TIMEOUT_CYCLES (bench overrides to 100) → rx_timeout high exactly 1 cycle at cycle 100 after the 5th byte; the next 16 bytes form a clean block.
- blk_in=0x00112233445566778899AABBCCDDEEFF, valid 1 cycle, uart_tx_ready modelled low for 50 cycles after each enable → 16 enable strobes carrying bytes 0x00,0x11,…,0xFF in order; blk_in_ready=0 until the 16th strobe has been issued, 1 again the cycle after.
- Assert rst for 1 cycle after the 7th TX byte and after the 9th RX byte → no further enables, blk_in_ready=1, blk_out_valid=0; the next 16 RX bytes produce a complete fresh block.
- Full-duplex: stream an RX block while a TX block is sending → both complete with correct data; no enable strobe is lost or duplicated.
